// File: rtl/bli201_biu_pkg.sv
// Shared types for the biu data-port arbiter: requester ids, ownership
// states and the data biu returns for unmapped reads.
package bli201_biu_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_OWN = 2'd1,
    DMA_OWN  = 2'd2
  } arb_state_t;

  localparam logic [31:0] BIU_UNMAPPED_DATA = 32'hCCCC_CCCC;

endpackage

// File: rtl/biu_dport_rsp.sv
// Data-phase tracker: remembers who owns the read in flight and steers the
// returning biu data to that requester, holding the last value per requester.
module biu_dport_rsp
  import bli201_biu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_gnt,
  input  req_id_t     gnt_owner,
  input  logic [31:0] drdata,
  output logic        core_rvalid,
  output logic        dma_rvalid,
  output logic [31:0] core_rdata,
  output logic [31:0] dma_rdata
);

  logic        rsp_pending_reg;
  req_id_t     rsp_owner_reg;
  logic [31:0] core_rdata_reg;
  logic [31:0] dma_rdata_reg;
  logic        rsp_live;

  // A read caught by reset is dropped, including during the reset cycle itself.
  assign rsp_live    = rsp_pending_reg & rst;
  assign core_rvalid = rsp_live & (rsp_owner_reg == M0);
  assign dma_rvalid  = rsp_live & (rsp_owner_reg == M1);
  assign core_rdata  = core_rvalid ? drdata : core_rdata_reg;
  assign dma_rdata   = dma_rvalid ? drdata : dma_rdata_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_pending_reg <= 1'b0;
      rsp_owner_reg   <= M0;
      core_rdata_reg  <= '0;
      dma_rdata_reg   <= '0;
    end else begin
      rsp_pending_reg <= rd_gnt;
      if (rd_gnt) rsp_owner_reg <= gnt_owner;
      if (core_rvalid) core_rdata_reg <= drdata;
      if (dma_rvalid) dma_rdata_reg <= drdata;
    end
  end

endmodule

// File: rtl/biu_dport_arb.sv
// Two-requester arbiter (core LSU = M0, DMA/debug loader = M1) for the biu
// data port. Optional perf counters are built when BIU_DPORT_ARB_PERF_EN is defined.
module biu_dport_arb
  import bli201_biu_pkg::*;
#(
  parameter int unsigned DMA_BURST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_i_req,
  input  logic [31:0] core_i_addr,
  input  logic [3:0]  core_i_wmask,
  input  logic [31:0] core_i_wdata,
  output logic        core_o_gnt,
  output logic        core_o_rvalid,
  output logic [31:0] core_o_rdata,
  input  logic        dma_i_req,
  input  logic [31:0] dma_i_addr,
  input  logic [3:0]  dma_i_wmask,
  input  logic [31:0] dma_i_wdata,
  output logic        dma_o_gnt,
  output logic        dma_o_rvalid,
  output logic [31:0] dma_o_rdata,
  output logic [31:0] arb_o_daddr,
  output logic [3:0]  arb_o_dwmask,
  output logic [31:0] arb_o_dwdata,
  input  logic [31:0] arb_i_drdata,
  output logic        arb_o_halt
`ifdef BIU_DPORT_ARB_PERF_EN
  ,
  output logic [31:0] arb_o_stall_cnt,
  output logic [31:0] arb_o_dma_cnt
`endif
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DMA_BURST);

  arb_state_t       state_reg, state_next;
  req_id_t          last_win_reg, last_win_next;
  logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  req_id_t          win;
  logic             any_gnt;

  // Winner selection; nothing is granted while reset is asserted.
  always_comb begin
    win     = M0;
    any_gnt = 1'b0;
    if (rst && (core_i_req || dma_i_req)) begin
      any_gnt = 1'b1;
      if (!dma_i_req)                win = M0;
      else if (!core_i_req)          win = M1;
      else if (state_reg == DMA_OWN) win = (burst_cnt_reg < BURST_MAX) ? M1 : M0;
      else                           win = (last_win_reg == M1) ? M0 : M1;
    end
  end

  always_comb begin
    state_next     = IDLE;
    last_win_next  = last_win_reg;
    burst_cnt_next = '0;
    if (any_gnt) begin
      last_win_next = win;
      if (win == M0) begin
        state_next = CORE_OWN;
      end else begin
        state_next = DMA_OWN;
        // Only grants taken from a waiting core count toward the burst limit.
        if (core_i_req && (burst_cnt_reg != BURST_MAX))
          burst_cnt_next = burst_cnt_reg + 1'b1;
        else
          burst_cnt_next = burst_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      last_win_reg  <= M1;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      last_win_reg  <= last_win_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  assign core_o_gnt = any_gnt & (win == M0);
  assign dma_o_gnt  = any_gnt & (win == M1);
  assign arb_o_halt = core_i_req & ~core_o_gnt;

  // Idle bus is forced to zero so biu never sees a stray write mask.
  always_comb begin
    arb_o_daddr  = '0;
    arb_o_dwmask = '0;
    arb_o_dwdata = '0;
    if (core_o_gnt) begin
      arb_o_daddr  = core_i_addr;
      arb_o_dwmask = core_i_wmask;
      arb_o_dwdata = core_i_wdata;
    end else if (dma_o_gnt) begin
      arb_o_daddr  = dma_i_addr;
      arb_o_dwmask = dma_i_wmask;
      arb_o_dwdata = dma_i_wdata;
    end
  end

  biu_dport_rsp u_rsp (
    .clk         (clk),
    .rst         (rst),
    .rd_gnt      (any_gnt & (arb_o_dwmask == 4'b0)),
    .gnt_owner   (win),
    .drdata      (arb_i_drdata),
    .core_rvalid (core_o_rvalid),
    .dma_rvalid  (dma_o_rvalid),
    .core_rdata  (core_o_rdata),
    .dma_rdata   (dma_o_rdata)
  );

`ifdef BIU_DPORT_ARB_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] dma_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      dma_cnt_reg   <= '0;
    end else begin
      if (arb_o_halt) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (dma_o_gnt)  dma_cnt_reg   <= dma_cnt_reg + 32'd1;
    end
  end

  assign arb_o_stall_cnt = stall_cnt_reg;
  assign arb_o_dma_cnt   = dma_cnt_reg;
`endif

endmodule
